comm_frame_ctrl: RTL and testbench

Frame scheduler placed in front of the transmit chain (IQ mapper → FIFO → IFFT → DA). On each frame request it drives the 32-bit word handshake of the transmit chain with a fixed preamble, a header word, a caller-supplied payload pulled from a word source, a checksum word, and then a silent guard gap. It serializes frame requests, numbers frames, and flags payload underrun, so the modulator sees well-formed, gap-bounded bursts.

---
 rtl/comm_frame_ctrl_pkg.sv | 37 +++
 rtl/comm_frame_cnt.sv | 49 ++++
 rtl/comm_frame_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_comm_frame_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comm_frame_ctrl_pkg
// Description : Shared comm definitions for the transmit-side frame
//               scheduler and the receive-side frame detector. It holds the
//               header magic, the default preamble words, the frame state
//               encoding and a helper that assembles the header word.
// Revision    : 1.0 - initial release
// ============================================================================
package comm_frame_ctrl_pkg;

    // Upper half of every header word; the receive side locks onto it.
    localparam logic [15:0] HDR_MAGIC = 16'hC35A;

    // Default preamble words: even preamble index / odd preamble index.
    localparam logic [31:0] DEF_PRE_A = 32'hA5A5_5A5A;
    localparam logic [31:0] DEF_PRE_B = 32'h5A5A_A5A5;

    // Frame phases. In the scheduler each state names the word class that
    // the next open load slot will place on the transmit register.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_PAY  = 3'd3,
        ST_CHK  = 3'd4,
        ST_GAP  = 3'd5
    } frame_state_e;

    // Header word layout: {magic, sequence number, payload length}.
    function automatic logic [31:0] make_header(input logic [7:0] seq,
                                                input logic [7:0] len);
        return {HDR_MAGIC, seq, len};
    endfunction

endpackage : comm_frame_ctrl_pkg
`default_nettype wire

// File: rtl/comm_frame_cnt.sv
`default_nettype none
// ============================================================================
// Module      : comm_frame_cnt
// Description : Loadable down-counter that saturates at zero. The frame
//               scheduler uses one instance each for the preamble words
//               left, the payload words left and the guard-gap cycles left.
// Ports       : CLK      - clock
//               RST      - asynchronous active-low reset (count -> 0)
//               load     - load load_val (takes priority over dec)
//               load_val - value to load
//               dec      - decrement by one when count is non-zero
//               count    - current count
// Revision    : 1.0 - initial release
// ============================================================================
module comm_frame_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : comm_frame_cnt
`default_nettype wire

// File: rtl/comm_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : comm_frame_ctrl
// Description : Frame scheduler in front of the transmit chain. Each accepted
//               request emits preamble, header, payload (pulled from a word
//               source) and a checksum on a registered valid/ack word
//               interface, followed by a silent guard gap.
// Ports       : CLK, RST    - clock, asynchronous active-low reset
//               req, len    - frame request and payload word count
//               busy        - frame in progress
//               frame_done  - pulse on the last guard-gap cycle
//               underrun    - sticky payload starvation flag
//               seq         - sequence number of current/last frame
//               pl_valid, pl_data, pl_rd - payload word source
//               tx_valid, tx_data, tx_ack - word handshake to transmit chain
// Revision    : 1.0 - initial release
// ============================================================================
module comm_frame_ctrl
    import comm_frame_ctrl_pkg::*;
#(
    parameter int          PRE_WORDS  = 4,
    parameter logic [31:0] PRE_A      = DEF_PRE_A,
    parameter logic [31:0] PRE_B      = DEF_PRE_B,
    parameter int          GAP_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic [7:0]  len,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun,
    output logic [7:0]  seq,
    input  logic        pl_valid,
    input  logic [31:0] pl_data,
    output logic        pl_rd,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ack
);

    // The first preamble word is loaded on acceptance, so the preamble
    // counter only tracks the words still to come.
    localparam logic [3:0] PRE_RELOAD    = 4'(PRE_WORDS - 1);
    localparam logic [9:0] GAP_RELOAD    = 10'(GAP_CYCLES);
    localparam logic       PRE_WORDS_ODD = ((PRE_WORDS % 2) == 1);

    frame_state_e state_q,    state_d;
    logic         tx_valid_q, tx_valid_d;
    logic [31:0]  tx_data_q,  tx_data_d;
    logic [31:0]  csum_q,     csum_d;
    logic [7:0]   seq_q,      seq_d;
    logic [7:0]   len_q,      len_d;
    logic         underrun_q, underrun_d;

    logic         pre_load, pre_dec;
    logic         pay_load, pay_dec;
    logic         gap_load, gap_dec;
    logic [3:0]   pre_cnt;
    logic [7:0]   pay_cnt;
    logic [9:0]   gap_cnt;

    logic         load_slot;
    logic         pre_odd;
    logic [31:0]  pre_word;
    logic [31:0]  hdr_word;

    comm_frame_cnt #(.WIDTH(4)) u_pre_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (pre_load),
        .load_val (PRE_RELOAD),
        .dec      (pre_dec),
        .count    (pre_cnt)
    );

    comm_frame_cnt #(.WIDTH(8)) u_pay_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (pay_load),
        .load_val (len_q),
        .dec      (pay_dec),
        .count    (pay_cnt)
    );

    comm_frame_cnt #(.WIDTH(10)) u_gap_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (gap_load),
        .load_val (GAP_RELOAD),
        .dec      (gap_dec),
        .count    (gap_cnt)
    );

    // The transmit register may take a new word when it is empty or its
    // current word is being consumed this cycle (no bubble under steady ack).
    assign load_slot = !tx_valid_q || tx_ack;

    // Next preamble index is PRE_WORDS - pre_cnt; only its parity matters,
    // which is the XOR of the two operands' parities.
    assign pre_odd  = pre_cnt[0] ^ PRE_WORDS_ODD;
    assign pre_word = pre_odd ? PRE_B : PRE_A;
    assign hdr_word = make_header(seq_q, len_q);

    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        csum_d     = csum_q;
        seq_d      = seq_q;
        len_d      = len_q;
        underrun_d = underrun_q;
        pre_load   = 1'b0;
        pre_dec    = 1'b0;
        pay_load   = 1'b0;
        pay_dec    = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        pl_rd      = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    len_d      = len;
                    seq_d      = seq_q + 8'd1;
                    underrun_d = 1'b0;
                    csum_d     = 32'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = PRE_A;
                    pre_load   = 1'b1;
                    state_d    = (PRE_WORDS == 1) ? ST_HDR : ST_PRE;
                end
            end

            ST_PRE: begin
                if (load_slot) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = pre_word;
                    pre_dec    = 1'b1;
                    if (pre_cnt == 4'd1) begin
                        state_d = ST_HDR;
                    end
                end
            end

            ST_HDR: begin
                if (load_slot) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = hdr_word;
                    csum_d     = hdr_word;
                    pay_load   = 1'b1;
                    state_d    = (len_q == 8'd0) ? ST_CHK : ST_PAY;
                end
            end

            ST_PAY: begin
                if (load_slot) begin
                    if (pl_valid) begin
                        pl_rd      = 1'b1;
                        tx_valid_d = 1'b1;
                        tx_data_d  = pl_data;
                        csum_d     = csum_q + pl_data;
                        pay_dec    = 1'b1;
                        if (pay_cnt == 8'd1) begin
                            state_d = ST_CHK;
                        end
                    end else begin
                        // Source starved: let the pending word go, present
                        // nothing, and keep waiting in PAY.
                        tx_valid_d = 1'b0;
                        underrun_d = 1'b1;
                    end
                end
            end

            ST_CHK: begin
                if (load_slot) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = csum_q;
                    gap_load   = 1'b1;
                    state_d    = ST_GAP;
                end
            end

            ST_GAP: begin
                // The checksum word is still on the register when GAP is
                // entered; gap cycles are counted only once it has left.
                if (tx_valid_q) begin
                    if (tx_ack) begin
                        tx_valid_d = 1'b0;
                        if (gap_cnt == 10'd0) begin
                            frame_done = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end
                end else begin
                    gap_dec = 1'b1;
                    if (gap_cnt <= 10'd1) begin
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 32'd0;
            csum_q     <= 32'd0;
            seq_q      <= 8'd0;
            len_q      <= 8'd0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            csum_q     <= csum_d;
            seq_q      <= seq_d;
            len_q      <= len_d;
            underrun_q <= underrun_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign underrun = underrun_q;
    assign seq      = seq_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

endmodule : comm_frame_ctrl
`default_nettype wire

// File: tb/tb_comm_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_comm_frame_ctrl
// Description : Self-checking bench for comm_frame_ctrl. Expected frames are
//               built from the frame format (preamble pattern, header
//               fields, payload, modular sum) and compared word by word with
//               what crosses the tx handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comm_frame_ctrl;

    localparam int          PRE_WORDS  = 4;
    localparam logic [31:0] PRE_A      = 32'hA5A5_5A5A;
    localparam logic [31:0] PRE_B      = 32'h5A5A_A5A5;
    localparam int          GAP_CYCLES = 64;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        pl_valid = 1'b0;
    logic [31:0] pl_data = 32'd0;
    logic        tx_ack = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        underrun;
    logic [7:0]  seq;
    logic        pl_rd;
    logic        tx_valid;
    logic [31:0] tx_data;

    comm_frame_ctrl #(
        .PRE_WORDS  (PRE_WORDS),
        .PRE_A      (PRE_A),
        .PRE_B      (PRE_B),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .len        (len),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun),
        .seq        (seq),
        .pl_valid   (pl_valid),
        .pl_data    (pl_data),
        .pl_rd      (pl_rd),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ack     (tx_ack)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          failures = 0;

    logic [31:0] src [256];
    int          src_idx = 0;
    logic [31:0] exp_q [$];
    logic [31:0] got [$];
    logic [7:0]  seq_log [$];
    int          exp_n = 0;
    int          exp_seq = 0;

    int          cyc = 0;
    int          first_x = -1;
    int          last_x = -1;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_und = 1'b0;
    int          bubble = 0;
    int          hold_err = 0;
    int          lat_err = 0;
    int          ack_mode = 0;
    int          pv_mode = 0;
    int          starve_after = 1;
    int          starve_left = 0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        lat_pend = 1'b0;
    logic [31:0] lat_word = 32'd0;
    logic        busy_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: observe at the falling edge, then drive just after the
    // rising edge so the DUT always sees stable inputs.
    task automatic tick();
        logic rd_s;
        @(negedge CLK);
        cyc++;
        if (prev_pend && !(tx_valid === 1'b1 && tx_data === prev_data)) hold_err++;
        if (lat_pend && (tx_data !== lat_word)) lat_err++;
        prev_pend = tx_valid && !tx_ack;
        prev_data = tx_data;
        lat_pend  = pl_rd;
        lat_word  = pl_data;
        if (tx_valid && tx_ack) begin
            got.push_back(tx_data);
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
        end
        if (busy && !tx_valid && got.size() > 0 && got.size() < exp_n) bubble++;
        if (pl_rd) rd_cnt++;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_und = underrun;
        end
        if (busy && !busy_prev) seq_log.push_back(seq);
        busy_prev = busy;
        rd_s = pl_rd;
        @(posedge CLK);
        #1;
        if (rd_s && src_idx < 255) src_idx++;
        pl_data = src[src_idx];
        case (ack_mode)
            0:       tx_ack = 1'b1;
            1:       tx_ack = ~tx_ack;
            default: tx_ack = 1'($urandom_range(0, 1));
        endcase
        case (pv_mode)
            0: pl_valid = 1'b1;
            1: pl_valid = ($urandom_range(0, 3) != 0);
            default: begin
                if (rd_cnt >= starve_after && starve_left > 0) begin
                    pl_valid = 1'b0;
                    starve_left--;
                end else begin
                    pl_valid = 1'b1;
                end
            end
        endcase
    endtask

    task automatic do_reset();
        RST = 1'b0;
        req = 1'b0;
        pl_valid = 1'b0;
        tx_ack = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        exp_seq = 0;
        prev_pend = 1'b0;
        lat_pend = 1'b0;
        busy_prev = 1'b0;
    endtask

    task automatic start_frame(input int l, input int am, input int pm, input bit directed);
        logic [31:0] sum;
        logic [31:0] hdr;
        for (int i = 0; i < 256; i++) src[i] = directed ? 32'(i + 1) : $urandom();
        exp_seq = (exp_seq + 1) % 256;
        exp_q.delete();
        for (int i = 0; i < PRE_WORDS; i++) exp_q.push_back((i % 2 == 0) ? PRE_A : PRE_B);
        hdr = {16'hC35A, 8'(exp_seq), 8'(l)};
        exp_q.push_back(hdr);
        sum = hdr;
        for (int i = 0; i < l; i++) begin
            exp_q.push_back(src[i]);
            sum = sum + src[i];
        end
        exp_q.push_back(sum);
        exp_n = exp_q.size();
        got.delete();
        first_x = -1; last_x = -1; rd_cnt = 0; done_cnt = 0; done_cyc = 0;
        done_und = 1'b0; bubble = 0; hold_err = 0; lat_err = 0;
        src_idx = 0; pl_data = src[0];
        ack_mode = am; pv_mode = pm; starve_left = 5; starve_after = 1;
        len = 8'(l);
        req = 1'b1;
        tick();
        check("accept_busy",     32'(busy),     32'd1);
        check("accept_tx_valid", 32'(tx_valid), 32'd1);
        check("accept_tx_data",  tx_data,       PRE_A);
        check("accept_seq",      32'(seq),      32'(exp_seq));
        check("accept_underrun", 32'(underrun), 32'd0);
    endtask

    task automatic run_frame(input int l, input int am, input int pm,
                             input bit directed, input bit hold_req);
        int budget;
        logic [31:0] obs;
        start_frame(l, am, pm, directed);
        if (!hold_req) req = 1'b0;
        budget = 0;
        while (done_cnt == 0 && budget < 4000) begin
            tick();
            budget++;
        end
        req = 1'b0;
        check("done_seen", 32'(done_cnt), 32'd1);
        check("word_count", 32'(got.size()), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            obs = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
            check($sformatf("len%0d_word%0d", l, i), obs, exp_q[i]);
        end
        check("pl_rd_count", 32'(rd_cnt),   32'(l));
        check("word_hold",   32'(hold_err), 32'd0);
        check("rd_latency",  32'(lat_err),  32'd0);
        check("gap_length",  32'(done_cyc - last_x), 32'(GAP_CYCLES));
        if (am == 0 && pm == 0) begin
            check("burst_span", 32'(last_x - first_x + 1), 32'(exp_n));
            check("no_bubble",  32'(bubble), 32'd0);
        end
        if (pm == 0) check("underrun_clear", 32'(done_und), 32'd0);
        if (pm == 2) begin
            check("underrun_at_done", 32'(done_und), 32'd1);
            check("bubble_seen", 32'(bubble != 0), 32'd1);
        end
        tick();
        check("idle_after_done", 32'(busy), 32'd0);
        check("single_done", 32'(done_cnt), 32'd1);
        if (pm == 2) check("underrun_sticky", 32'(underrun), 32'd1);
    endtask

    initial begin
        int budget;
        #2;
        RST = 1'b0;
        #1;
        check("rst_tx_valid",   32'(tx_valid),   32'd0);
        check("rst_tx_data",    tx_data,         32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_underrun",   32'(underrun),   32'd0);
        check("rst_seq",        32'(seq),        32'd0);
        check("rst_pl_rd",      32'(pl_rd),      32'd0);
        do_reset();
        repeat (2) tick();

        // Directed frame with payload 1,2,3 and steady ack.
        run_frame(3, 0, 0, 1'b1, 1'b0);
        check("csum_literal", (got.size() == 9) ? got[8] : 32'hxxxx_xxxx, 32'hC35A_0109);
        // Empty payload.
        run_frame(0, 0, 0, 1'b0, 1'b0);
        check("hdr_len0", (got.size() >= 5) ? got[4] : 32'hxxxx_xxxx, 32'hC35A_0200);
        // Alternating ack.
        run_frame(2, 1, 0, 1'b0, 1'b0);
        // Source starved for five cycles mid-payload.
        run_frame(4, 0, 2, 1'b0, 1'b0);
        // Random ack and payload availability, req held through busy.
        run_frame(5, 2, 1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) run_frame(int'($urandom_range(0, 20)), 2, 1, 1'b0, 1'b0);

        // Reset asserted in the middle of a payload.
        start_frame(10, 0, 0, 1'b0);
        req = 1'b0;
        budget = 0;
        while (rd_cnt < 3 && budget < 200) begin
            tick();
            budget++;
        end
        check("reached_payload", 32'(rd_cnt >= 3), 32'd1);
        RST = 1'b0;
        #1;
        check("mid_rst_tx_valid",   32'(tx_valid),   32'd0);
        check("mid_rst_tx_data",    tx_data,         32'd0);
        check("mid_rst_busy",       32'(busy),       32'd0);
        check("mid_rst_seq",        32'(seq),        32'd0);
        check("mid_rst_underrun",   32'(underrun),   32'd0);
        check("mid_rst_pl_rd",      32'(pl_rd),      32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        do_reset();
        tick();
        run_frame(2, 0, 0, 1'b0, 1'b0);

        // 256 back-to-back frames with req held high throughout.
        do_reset();
        tick();
        for (int i = 0; i < 256; i++) src[i] = $urandom();
        src_idx = 0;
        exp_n = 0;
        seq_log.delete();
        got.delete();
        done_cnt = 0;
        ack_mode = 0;
        pv_mode = 0;
        len = 8'd1;
        req = 1'b1;
        budget = 0;
        while (done_cnt < 256 && budget < 30000) begin
            tick();
            budget++;
        end
        req = 1'b0;
        tick();
        check("b2b_frames", 32'(done_cnt), 32'd256);
        check("b2b_words", 32'(got.size()), 32'(256 * (PRE_WORDS + 3)));
        check("b2b_seq_count", 32'(seq_log.size()), 32'd256);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("b2b_seq%0d", i),
                  (i < seq_log.size()) ? 32'(seq_log[i]) : 32'hxxxx_xxxx,
                  32'((i + 1) % 256));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_comm_frame_ctrl
`default_nettype wire
